// File: rtl/aes_ctrl_pkg.sv
// aes_ctrl_pkg
// Shared definitions for the AES round sequencer: the controller state
// encoding, the round counts of the three AES key sizes, and a helper that
// tells whether a round count names a real AES variant.
package aes_ctrl_pkg;

    // Controller phases. IDLE waits for a block, INIT does the initial
    // AddRoundKey, ROUND covers the middle rounds, FINAL is the round without
    // MixColumns, HOLD presents the result until it is consumed.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        INIT  = 3'd1,
        ROUND = 3'd2,
        FINAL = 3'd3,
        HOLD  = 3'd4
    } aes_ctrl_state_t;

    localparam int AES128_ROUNDS = 10;
    localparam int AES192_ROUNDS = 12;
    localparam int AES256_ROUNDS = 14;

    // True only for the round counts of AES-128, AES-192 and AES-256.
    function automatic bit legal_rounds(input int n);
        return (n == AES128_ROUNDS) || (n == AES192_ROUNDS) || (n == AES256_ROUNDS);
    endfunction

endpackage

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl
// Round sequencer for the AES cipher datapath. Accepts a block, walks the
// datapath through initial AddRoundKey, the middle rounds and the final
// round, pulses the text_out load, then holds the result behind a
// valid/ready handshake.
//
// Ports
//   clk          in   single clock, rising edge
//   rst          in   asynchronous reset, active low
//   start_valid  in   a new block (text_in/key) is present
//   start_ready  out  controller can accept a block this cycle
//   abort        in   synchronous abort of the block in flight
//   round_cnt    out  current round index, 0..NUM_ROUNDS
//   first_round  out  selects text_in^key into the state register
//   last_round   out  bypasses MixColumns
//   key_ld       out  loads the key schedule from the input key
//   key_en       out  advances the key schedule by one round
//   dp_en        out  state register capture enable
//   out_ld       out  text_out register load strobe
//   out_valid    out  text_out holds an unconsumed result
//   out_ready    in   downstream accepts the result
//   busy         out  controller is not idle
module aes_round_ctrl
    import aes_ctrl_pkg::*;
#(
    parameter int NUM_ROUNDS = AES128_ROUNDS,
    parameter int RCNT_W     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_valid,
    output logic              start_ready,
    input  logic              abort,
    output logic [RCNT_W-1:0] round_cnt,
    output logic              first_round,
    output logic              last_round,
    output logic              key_ld,
    output logic              key_en,
    output logic              dp_en,
    output logic              out_ld,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy
);

    if (!legal_rounds(NUM_ROUNDS)) begin : g_bad_rounds
        $error("aes_round_ctrl: NUM_ROUNDS must be 10, 12 or 14");
    end

    if (RCNT_W < $clog2(NUM_ROUNDS + 1)) begin : g_bad_rcnt_w
        $error("aes_round_ctrl: RCNT_W too narrow for NUM_ROUNDS");
    end

    localparam logic [RCNT_W-1:0] LAST_MID_CNT = RCNT_W'(NUM_ROUNDS - 1);
    localparam logic [RCNT_W-1:0] FINAL_CNT    = RCNT_W'(NUM_ROUNDS);

    aes_ctrl_state_t   state_q, state_d;
    logic [RCNT_W-1:0] rcnt_q, rcnt_d;

    // Next state and next round count. The counter is only ever loaded with
    // 0, its increment inside ROUND, or NUM_ROUNDS on the way into FINAL, so
    // it cannot wrap. An abort overrides whatever the phase logic decided.
    always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        case (state_q)
            IDLE: begin
                rcnt_d = '0;
                if (start_valid) begin
                    state_d = INIT;
                end
            end
            INIT: begin
                state_d = ROUND;
                rcnt_d  = RCNT_W'(1);
            end
            ROUND: begin
                if (rcnt_q == LAST_MID_CNT) begin
                    state_d = FINAL;
                    rcnt_d  = FINAL_CNT;
                end else begin
                    rcnt_d = rcnt_q + RCNT_W'(1);
                end
            end
            FINAL: begin
                state_d = HOLD;
            end
            HOLD: begin
                // Taking a new block straight out of HOLD avoids an idle
                // bubble between back-to-back blocks.
                if (out_ready) begin
                    state_d = start_valid ? INIT : IDLE;
                    rcnt_d  = '0;
                end
            end
            default: begin
                state_d = IDLE;
                rcnt_d  = '0;
            end
        endcase
        if (abort) begin
            state_d = IDLE;
            rcnt_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            rcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            rcnt_q  <= rcnt_d;
        end
    end

    // Outputs are pure decodes of the phase; abort gates the two strobes
    // that would otherwise commit work in the abort cycle.
    always_comb begin
        start_ready = ((state_q == IDLE) || ((state_q == HOLD) && out_ready)) && !abort;
        first_round = (state_q == INIT);
        key_ld      = (state_q == INIT);
        last_round  = (state_q == FINAL);
        dp_en       = (state_q == INIT) || (state_q == ROUND) || (state_q == FINAL);
        key_en      = (state_q == ROUND) || (state_q == FINAL);
        out_ld      = (state_q == FINAL) && !abort;
        out_valid   = (state_q == HOLD);
        busy        = (state_q != IDLE);
        round_cnt   = rcnt_q;
    end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb_aes_round_ctrl
// Drives an AES-128 and an AES-256 round sequencer from the same inputs and
// compares both against a block-level reference: each accepted block is
// tracked only by its accept cycle, and every output follows from how many
// cycles have elapsed since then.
module tb_aes_round_ctrl;

    typedef struct packed {
        logic       startReady;
        logic       firstRound;
        logic       lastRound;
        logic       keyLd;
        logic       keyEn;
        logic       dpEn;
        logic       outLd;
        logic       outValid;
        logic       busy;
        logic [3:0] roundCnt;
    } outs_t;

    typedef struct {
        int    cyc;
        outs_t exp0;
        outs_t exp1;
    } entry_t;

    logic clk;
    logic rst;
    logic startValid;
    logic abortIn;
    logic outReady;

    outs_t obs [2];

    int cycle;
    int checks;
    int failures;

    entry_t cycQ [$];
    int     ldQ0 [$];
    int     ldQ1 [$];

    int roundsOf [2] = '{10, 14};
    bit inFlight [2];
    int acceptCyc [2];

    aes_round_ctrl #(.NUM_ROUNDS(10), .RCNT_W(4)) dut10 (
        .clk         (clk),
        .rst         (rst),
        .start_valid (startValid),
        .start_ready (obs[0].startReady),
        .abort       (abortIn),
        .round_cnt   (obs[0].roundCnt),
        .first_round (obs[0].firstRound),
        .last_round  (obs[0].lastRound),
        .key_ld      (obs[0].keyLd),
        .key_en      (obs[0].keyEn),
        .dp_en       (obs[0].dpEn),
        .out_ld      (obs[0].outLd),
        .out_valid   (obs[0].outValid),
        .out_ready   (outReady),
        .busy        (obs[0].busy)
    );

    aes_round_ctrl #(.NUM_ROUNDS(14), .RCNT_W(4)) dut14 (
        .clk         (clk),
        .rst         (rst),
        .start_valid (startValid),
        .start_ready (obs[1].startReady),
        .abort       (abortIn),
        .round_cnt   (obs[1].roundCnt),
        .first_round (obs[1].firstRound),
        .last_round  (obs[1].lastRound),
        .key_ld      (obs[1].keyLd),
        .key_en      (obs[1].keyEn),
        .dp_en       (obs[1].dpEn),
        .out_ld      (obs[1].outLd),
        .out_valid   (obs[1].outValid),
        .out_ready   (outReady),
        .busy        (obs[1].busy)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle number shared by stimulus and monitor; it advances on each
    // rising edge so both sides agree on which cycle they are looking at.
    always @(posedge clk) begin
        cycle <= cycle + 1;
    end

    // Expected outputs of one controller in a cycle, from the block phase:
    // e is the number of cycles since the block was accepted. e=1 is the
    // initial key addition, e=n+1 the final round, beyond that the result
    // is held.
    function automatic outs_t modelOutputs(input int n, input bit fl, input int e,
                                           input bit ab, input bit ordy);
        outs_t o;
        o = '0;
        if (!fl) begin
            o.startReady = !ab;
        end else begin
            o.busy = 1'b1;
            if (e <= n + 1) begin
                o.roundCnt   = 4'(e - 1);
                o.firstRound = (e == 1);
                o.keyLd      = (e == 1);
                o.dpEn       = 1'b1;
                o.keyEn      = (e >= 2);
                o.lastRound  = (e == n + 1);
                o.outLd      = (e == n + 1) && !ab;
            end else begin
                o.roundCnt   = 4'(n);
                o.outValid   = 1'b1;
                o.startReady = ordy && !ab;
            end
        end
        return o;
    endfunction

    task automatic pushLd(input int i, input int v);
        if (i == 0) ldQ0.push_back(v);
        else        ldQ1.push_back(v);
    endtask

    task automatic dropPendingLd(input int i);
        if (i == 0) begin
            if (ldQ0.size() > 0) void'(ldQ0.pop_back());
        end else begin
            if (ldQ1.size() > 0) void'(ldQ1.pop_back());
        end
    endtask

    // Moves one controller's block bookkeeping across the coming edge.
    task automatic advanceModel(input int i, input int c, input bit sv,
                                input bit ab, input bit ordy);
        int n;
        int e;
        n = roundsOf[i];
        e = c - acceptCyc[i];
        if (ab) begin
            if (inFlight[i] && e <= n + 1) dropPendingLd(i);
            inFlight[i] = 1'b0;
        end else if (!inFlight[i]) begin
            if (sv) begin
                inFlight[i]  = 1'b1;
                acceptCyc[i] = c;
                pushLd(i, c + n + 1);
            end
        end else if (e >= n + 2 && ordy) begin
            if (sv) begin
                acceptCyc[i] = c;
                pushLd(i, c + n + 1);
            end else begin
                inFlight[i] = 1'b0;
            end
        end
    endtask

    // One cycle of stimulus: drive the inputs just after the edge, queue
    // what both controllers should show this cycle, then advance the model.
    task automatic applyStimulus(input bit sv, input bit ab, input bit ordy);
        entry_t ent;
        @(posedge clk);
        #1;
        rst        = 1'b1;
        startValid = sv;
        abortIn    = ab;
        outReady   = ordy;
        ent.cyc  = cycle;
        ent.exp0 = modelOutputs(roundsOf[0], inFlight[0], cycle - acceptCyc[0], ab, ordy);
        ent.exp1 = modelOutputs(roundsOf[1], inFlight[1], cycle - acceptCyc[1], ab, ordy);
        cycQ.push_back(ent);
        for (int i = 0; i < 2; i++) advanceModel(i, cycle, sv, ab, ordy);
    endtask

    // Holds reset low for one cycle; everything in flight is forgotten.
    task automatic applyReset();
        entry_t ent;
        @(posedge clk);
        #1;
        rst        = 1'b0;
        startValid = 1'b0;
        abortIn    = 1'b0;
        outReady   = 1'b0;
        ent.cyc  = cycle;
        ent.exp0 = modelOutputs(roundsOf[0], 1'b0, 0, 1'b0, 1'b0);
        ent.exp1 = modelOutputs(roundsOf[1], 1'b0, 0, 1'b0, 1'b0);
        cycQ.push_back(ent);
        inFlight[0] = 1'b0;
        inFlight[1] = 1'b0;
        ldQ0.delete();
        ldQ1.delete();
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h",
                     name, cycle, actual, expected);
        end
    endtask

    // Text_out loads are matched against the block that should produce them.
    task automatic checkLd(input int i);
        int expCyc;
        if (i == 0) expCyc = (ldQ0.size() > 0) ? ldQ0.pop_front() : -1;
        else        expCyc = (ldQ1.size() > 0) ? ldQ1.pop_front() : -1;
        checkOutput(i == 0 ? "outLdCycle10" : "outLdCycle14", cycle, expCyc);
    endtask

    // Monitor: on the falling edge, pop this cycle's expectation and compare
    // every output of both controllers; on a load strobe, also consume the
    // matching scheduled load.
    always @(negedge clk) begin
        entry_t ent;
        if (cycQ.size() > 0) begin
            ent = cycQ.pop_front();
            checkOutput("cycleAlign", cycle, ent.cyc);
            checkOutput("outputs10", int'(obs[0]), int'(ent.exp0));
            checkOutput("outputs14", int'(obs[1]), int'(ent.exp1));
            for (int i = 0; i < 2; i++) begin
                if (obs[i].outLd) checkLd(i);
            end
        end
    end

    // Test sequence: reset, directed scenarios, then random traffic.
    initial begin
        rst        = 1'b0;
        startValid = 1'b0;
        abortIn    = 1'b0;
        outReady   = 1'b0;
        cycle      = 0;
        checks     = 0;
        failures   = 0;
        inFlight   = '{1'b0, 1'b0};
        acceptCyc  = '{0, 0};

        applyReset();
        repeat (2) applyStimulus(1'b0, 1'b0, 1'b0);

        $display("[TB] single block with downstream always ready");
        applyStimulus(1'b1, 1'b0, 1'b1);
        repeat (18) applyStimulus(1'b0, 1'b0, 1'b1);

        $display("[TB] back-to-back blocks");
        repeat (40) applyStimulus(1'b1, 1'b0, 1'b1);
        repeat (18) applyStimulus(1'b0, 1'b0, 1'b1);

        $display("[TB] result stalled in hold");
        applyStimulus(1'b1, 1'b0, 1'b0);
        repeat (36) applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);

        $display("[TB] abort mid-round and in hold");
        applyStimulus(1'b1, 1'b0, 1'b0);
        repeat (7) applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        repeat (17) applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1);
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);

        $display("[TB] reset in the middle of the rounds");
        applyStimulus(1'b1, 1'b0, 1'b0);
        repeat (5) applyStimulus(1'b0, 1'b0, 1'b0);
        applyReset();
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b1);

        $display("[TB] random traffic");
        for (int k = 0; k < 1500; k++) begin
            applyStimulus(($urandom_range(1, 0) == 1),
                          ($urandom_range(39, 0) == 0),
                          ($urandom_range(2, 0) != 0));
        end

        repeat (20) applyStimulus(1'b0, 1'b0, 1'b1);
        @(negedge clk);
        #1;
        checkOutput("ldQueueEmpty10", ldQ0.size(), 0);
        checkOutput("ldQueueEmpty14", ldQ1.size(), 0);
        checkOutput("cycQueueEmpty", cycQ.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
